// File: rtl/cma_host_ctrl.sv
// ----------------------------------------------------------------------------
// cma_host_ctrl
//
// Purpose:
//   Bridges a host command/response channel onto the CMA strobe interface.
//   The host issues write, read, run, set-bank and set-ROMUL commands. Reads
//   return one captured word on the response channel. A run raises RUN and
//   waits for the CMA to signal DONE.
//
// Configuration:
//   CMA_HOST_TIMEOUT_EN : when defined, RUN_WAIT is bounded by a 16-bit cycle
//                         counter. After TIMEOUT_CYC cycles without DONE the
//                         run is aborted and ERR is set. When undefined there
//                         is no counter and RUN_WAIT waits indefinitely.
//
// Parameters:
//   TIMEOUT_CYC  maximum RUN_WAIT cycles before abort (timeout build only)
//
// Ports:
//   CLK, RST_N            clock (rising edge), asynchronous active-low reset
//   CMD_VALID/CMD_READY   command handshake
//   CMD_OP[2:0]           000 write, 001 read, 010 run, 011 set bank,
//                         100 set ROMUL, others illegal
//   CMD_ADDR[11:0]        CMA address
//   CMD_DATA[24:0]        write data, bank select [0] or ROMUL value [19:0]
//   RSP_VALID/RSP_READY   read response handshake
//   RSP_DATA[24:0]        captured read word (held after the handshake)
//   EXWE, EXRE            CMA write / read strobes
//   EXA[11:0], EXWD[24:0] CMA address / write data
//   EXRD[24:0]            CMA read data, valid the cycle after EXRE
//   EXROMUL[19:0], CBANK  CMA ROMUL value and configuration bank
//   RUN, DONE             CMA run request / completion
//   BUSY                  high whenever the FSM is not idle
//   ERR                   sticky error (illegal opcode or run timeout)
//
// Handshake rule: a transfer happens at a rising CLK edge where VALID and
// READY are both 1. A VALID source keeps its payload stable until that edge.
// The CMD channel is ready only in IDLE. RSP_VALID and RSP_DATA hold until
// RSP_READY is sampled high.
// ----------------------------------------------------------------------------
module cma_host_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [2:0]  CMD_OP,
    input  logic [11:0] CMD_ADDR,
    input  logic [24:0] CMD_DATA,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [24:0] RSP_DATA,
    output logic        EXWE,
    output logic        EXRE,
    output logic [11:0] EXA,
    output logic [24:0] EXWD,
    input  logic [24:0] EXRD,
    output logic [19:0] EXROMUL,
    output logic        CBANK,
    output logic        RUN,
    input  logic        DONE,
    output logic        BUSY,
    output logic        ERR
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        READ     = 3'd2,
        RD_CAP   = 3'd3,
        RSP      = 3'd4,
        RUN_WAIT = 3'd5
    } state_t;

    localparam logic [2:0] OP_WRITE = 3'b000;
    localparam logic [2:0] OP_READ  = 3'b001;
    localparam logic [2:0] OP_RUN   = 3'b010;
    localparam logic [2:0] OP_BANK  = 3'b011;
    localparam logic [2:0] OP_ROMUL = 3'b100;

    state_t state;

    // High only during the first RUN_WAIT cycle. DONE may still be high from
    // a previous run, so it is not trusted until this flag has cleared.
    logic run_first;

`ifdef CMA_HOST_TIMEOUT_EN
    // Counts completed RUN_WAIT cycles. When it equals TO_LAST, the cycle
    // being closed is the TIMEOUT_CYC-th one, so RUN stays high for exactly
    // TIMEOUT_CYC cycles before an abort.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] to_cnt;
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

    // These two outputs decode only the state register.
    assign CMD_READY = (state == IDLE);
    assign BUSY      = (state != IDLE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            run_first <= 1'b0;
            EXWE      <= 1'b0;
            EXRE      <= 1'b0;
            RUN       <= 1'b0;
            RSP_VALID <= 1'b0;
            ERR       <= 1'b0;
            CBANK     <= 1'b0;
            EXA       <= '0;
            EXWD      <= '0;
            EXROMUL   <= '0;
            RSP_DATA  <= '0;
`ifdef CMA_HOST_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (CMD_VALID) begin
                        case (CMD_OP)
                            OP_WRITE: begin
                                EXA   <= CMD_ADDR;
                                EXWD  <= CMD_DATA;
                                EXWE  <= 1'b1;
                                state <= WRITE;
                            end
                            OP_READ: begin
                                EXA   <= CMD_ADDR;
                                EXRE  <= 1'b1;
                                state <= READ;
                            end
                            OP_RUN: begin
                                RUN       <= 1'b1;
                                run_first <= 1'b1;
`ifdef CMA_HOST_TIMEOUT_EN
                                to_cnt    <= '0;
`endif
                                state     <= RUN_WAIT;
                            end
                            OP_BANK: begin
                                CBANK <= CMD_DATA[0];
                            end
                            OP_ROMUL: begin
                                EXROMUL <= CMD_DATA[19:0];
                            end
                            default: begin
                                // Illegal opcode: consumed, flagged, no strobe.
                                ERR <= 1'b1;
                            end
                        endcase
                    end
                end

                WRITE: begin
                    EXWE  <= 1'b0;
                    state <= IDLE;
                end

                READ: begin
                    EXRE  <= 1'b0;
                    state <= RD_CAP;
                end

                RD_CAP: begin
                    // The CMA presents EXRD in the cycle after EXRE.
                    RSP_DATA  <= EXRD;
                    RSP_VALID <= 1'b1;
                    state     <= RSP;
                end

                RSP: begin
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        state     <= IDLE;
                    end
                end

                RUN_WAIT: begin
                    run_first <= 1'b0;
`ifdef CMA_HOST_TIMEOUT_EN
                    to_cnt <= to_cnt + 16'd1;
                    // A qualified DONE wins over a simultaneous timeout.
                    if (!run_first && DONE) begin
                        RUN   <= 1'b0;
                        state <= IDLE;
                    end else if (to_cnt == TO_LAST) begin
                        RUN   <= 1'b0;
                        ERR   <= 1'b1;
                        state <= IDLE;
                    end
`else
                    if (!run_first && DONE) begin
                        RUN   <= 1'b0;
                        state <= IDLE;
                    end
`endif
                end

                default: begin
                    EXWE      <= 1'b0;
                    EXRE      <= 1'b0;
                    RUN       <= 1'b0;
                    RSP_VALID <= 1'b0;
                    run_first <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cma_host_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cma_host_ctrl
//
// Directed bench for cma_host_ctrl. Builds with or without the
// CMA_HOST_TIMEOUT_EN macro. With the macro defined it checks the run
// timeout (TIMEOUT_CYC = 20). Without it, it checks that a run with no DONE
// is still pending after 1000 cycles.
// A small CMA model returns EXRD in the cycle after EXRE and 0 otherwise.
// Inputs change #1 after a rising edge. Outputs are checked at that point.
// ----------------------------------------------------------------------------
module tb_cma_host_ctrl;

    localparam logic [2:0] OP_WRITE = 3'b000;
    localparam logic [2:0] OP_READ  = 3'b001;
    localparam logic [2:0] OP_RUN   = 3'b010;
    localparam logic [2:0] OP_BANK  = 3'b011;
    localparam logic [2:0] OP_ROMUL = 3'b100;
    localparam logic [2:0] OP_ILL   = 3'b111;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [11:0] cmd_addr;
    logic [24:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [24:0] rsp_data;
    logic        exwe;
    logic        exre;
    logic [11:0] exa;
    logic [24:0] exwd;
    logic [24:0] exrd;
    logic [19:0] exromul;
    logic        cbank;
    logic        run;
    logic        done;
    logic        busy;
    logic        err;

    logic [24:0] rd_word;
    logic [24:0] exp_q[$];
    logic [24:0] exp_word;

    int checks;
    int errors;
    int exwe_cnt;
    int exre_cnt;
    int overlap_cnt;

    cma_host_ctrl #(.TIMEOUT_CYC(20)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .CMD_VALID (cmd_valid),
        .CMD_READY (cmd_ready),
        .CMD_OP    (cmd_op),
        .CMD_ADDR  (cmd_addr),
        .CMD_DATA  (cmd_data),
        .RSP_VALID (rsp_valid),
        .RSP_READY (rsp_ready),
        .RSP_DATA  (rsp_data),
        .EXWE      (exwe),
        .EXRE      (exre),
        .EXA       (exa),
        .EXWD      (exwd),
        .EXRD      (exrd),
        .EXROMUL   (exromul),
        .CBANK     (cbank),
        .RUN       (run),
        .DONE      (done),
        .BUSY      (busy),
        .ERR       (err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- CMA model ----------------
    always @(posedge clk) begin
        exrd <= exre ? rd_word : 25'h0;
    end

    // Strobe activity monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (exwe) exwe_cnt++;
            if (exre) exre_cnt++;
            if ((int'(exwe) + int'(exre) + int'(run)) > 1) overlap_cnt++;
        end
    end

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called #1 after an edge. Returns #1 after the accept edge.
    task automatic send_cmd(input logic [2:0] op, input logic [11:0] addr,
                            input logic [24:0] data);
        check_val("cmd_ready_pre", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        tick(1);
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_addr  = '0;
        cmd_data  = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int e0;
    int r0;
    int w0;
    int n;

    initial begin
        checks = 0; errors = 0;
        exwe_cnt = 0; exre_cnt = 0; overlap_cnt = 0;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
        rsp_ready = 1'b0; done = 1'b0; rd_word = '0;

        // Reset state
        tick(3);
        check_val("rst_exwe",   32'(exwe), 32'd0);
        check_val("rst_exre",   32'(exre), 32'd0);
        check_val("rst_run",    32'(run), 32'd0);
        check_val("rst_rspv",   32'(rsp_valid), 32'd0);
        check_val("rst_err",    32'(err), 32'd0);
        check_val("rst_cbank",  32'(cbank), 32'd0);
        check_val("rst_exa",    32'(exa), 32'd0);
        check_val("rst_exwd",   32'(exwd), 32'd0);
        check_val("rst_romul",  32'(exromul), 32'd0);
        check_val("rst_rspd",   32'(rsp_data), 32'd0);
        check_val("rst_busy",   32'(busy), 32'd0);
        rst_n = 1'b1;
        check_val("rel_ready",  32'(cmd_ready), 32'd1);
        tick(1);

        // Write: one EXWE cycle, ready again two cycles after accept
        w0 = exwe_cnt;
        send_cmd(OP_WRITE, 12'h123, 25'h1ABCDEF);
        check_val("wr_exwe",    32'(exwe), 32'd1);
        check_val("wr_exa",     32'(exa), 32'h123);
        check_val("wr_exwd",    32'(exwd), 32'h1ABCDEF);
        check_val("wr_ready0",  32'(cmd_ready), 32'd0);
        check_val("wr_busy",    32'(busy), 32'd1);
        tick(1);
        check_val("wr_exwe_off", 32'(exwe), 32'd0);
        check_val("wr_ready1",  32'(cmd_ready), 32'd1);
        check_val("wr_pulses",  32'(exwe_cnt - w0), 32'd1);

        // Read with response back-pressure
        rd_word = 25'h0055AA1;
        exp_q.push_back(25'h0055AA1);
        r0 = exre_cnt;
        send_cmd(OP_READ, 12'h040, 25'h0);
        check_val("rd_exre",    32'(exre), 32'd1);
        check_val("rd_exa",     32'(exa), 32'h040);
        tick(1);
        check_val("rd_exre_off", 32'(exre), 32'd0);
        check_val("rd_rspv_cap", 32'(rsp_valid), 32'd0);
        tick(1);
        exp_word = exp_q[0];
        check_val("rd_rspv",    32'(rsp_valid), 32'd1);
        check_val("rd_rspd",    32'(rsp_data), 32'(exp_word));
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_val("rd_hold_v", 32'(rsp_valid), 32'd1);
            check_val("rd_hold_d", 32'(rsp_data), 32'(exp_word));
        end
        rsp_ready = 1'b1;
        tick(1);
        rsp_ready = 1'b0;
        void'(exp_q.pop_front());
        check_val("rd_rspv_off", 32'(rsp_valid), 32'd0);
        check_val("rd_retain",  32'(rsp_data), 32'h0055AA1);
        check_val("rd_ready",   32'(cmd_ready), 32'd1);
        check_val("rd_pulses",  32'(exre_cnt - r0), 32'd1);

        // Run with stale DONE, then DONE ten cycles after accept
        done = 1'b1;
        send_cmd(OP_RUN, 12'h0, 25'h0);
        check_val("run_on",     32'(run), 32'd1);
        tick(1);
        check_val("run_stale",  32'(run), 32'd1);
        check_val("run_busy",   32'(busy), 32'd1);
        done = 1'b0;
        tick(8);
        check_val("run_wait",   32'(run), 32'd1);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        check_val("run_done",   32'(run), 32'd0);
        check_val("run_ready",  32'(cmd_ready), 32'd1);
        check_val("run_err",    32'(err), 32'd0);

        // Bank / ROMUL configuration persists across writes
        send_cmd(OP_BANK, 12'h0, 25'h1);
        check_val("bank_set",   32'(cbank), 32'd1);
        check_val("bank_idle",  32'(busy), 32'd0);
        send_cmd(OP_ROMUL, 12'h0, 25'h0FACE5);
        check_val("romul_set",  32'(exromul), 32'hFACE5);
        send_cmd(OP_WRITE, 12'h7FF, 25'h0000001);
        tick(1);
        send_cmd(OP_WRITE, 12'h001, 25'h1FFFFFF);
        check_val("wr2_exwd",   32'(exwd), 32'h1FFFFFF);
        tick(1);
        check_val("bank_keep",  32'(cbank), 32'd1);
        check_val("romul_keep", 32'(exromul), 32'hFACE5);

        // Illegal opcode
        e0 = exwe_cnt;
        r0 = exre_cnt;
        send_cmd(OP_ILL, 12'h555, 25'h0);
        check_val("ill_err",    32'(err), 32'd1);
        check_val("ill_busy",   32'(busy), 32'd0);
        check_val("ill_run",    32'(run), 32'd0);
        tick(2);
        check_val("ill_noexwe", 32'(exwe_cnt - e0), 32'd0);
        check_val("ill_noexre", 32'(exre_cnt - r0), 32'd0);

        // Run without DONE
        do_reset();
        check_val("rst2_err",   32'(err), 32'd0);
        check_val("rst2_cbank", 32'(cbank), 32'd0);
`ifdef CMA_HOST_TIMEOUT_EN
        send_cmd(OP_RUN, 12'h0, 25'h0);
        n = 1;
        for (int i = 0; i < 100 && run; i++) begin
            tick(1);
            if (run) n++;
        end
        check_val("to_cycles",  32'(n), 32'd20);
        check_val("to_err",     32'(err), 32'd1);
        check_val("to_ready",   32'(cmd_ready), 32'd1);
        send_cmd(OP_RUN, 12'h0, 25'h0);
        tick(3);
`else
        send_cmd(OP_RUN, 12'h0, 25'h0);
        tick(999);
        check_val("noto_run",   32'(run), 32'd1);
        check_val("noto_busy",  32'(busy), 32'd1);
        check_val("noto_err",   32'(err), 32'd0);
`endif

        // Reset during RUN_WAIT
        check_val("rr_run_pre", 32'(run), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rr_run",     32'(run), 32'd0);
        check_val("rr_busy",    32'(busy), 32'd0);
        check_val("rr_err",     32'(err), 32'd0);
        #2;
        rst_n = 1'b1;
        tick(1);
        check_val("rr_ready",   32'(cmd_ready), 32'd1);
        check_val("rr_run2",    32'(run), 32'd0);

        // Reset during RSP
        rd_word = 25'h1234567;
        exp_q.push_back(25'h1234567);
        send_cmd(OP_READ, 12'h0AA, 25'h0);
        tick(2);
        exp_word = exp_q.pop_front();
        check_val("rs_rspv",    32'(rsp_valid), 32'd1);
        check_val("rs_rspd",    32'(rsp_data), 32'(exp_word));
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rs_rspv_off", 32'(rsp_valid), 32'd0);
        check_val("rs_rspd_clr", 32'(rsp_data), 32'd0);
        #2;
        rst_n = 1'b1;
        tick(1);
        check_val("rs_ready",   32'(cmd_ready), 32'd1);
        tick(3);
        check_val("rs_no_rsp",  32'(rsp_valid), 32'd0);

        // Global properties
        check_val("strobe_overlap", 32'(overlap_cnt), 32'd0);
        check_val("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cma_host_ctrl.md
CMA_HOST_CTRL -- requirements
Module: cma_host_ctrl

Interface
REQ-001 Parameters SHALL be:
- TIMEOUT_CYC, default 65535, maximum RUN_WAIT cycles before abort; used only with CMA_HOST_TIMEOUT_EN.
REQ-002 Ports SHALL be:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- CMD_VALID  in  1  host command valid.
- CMD_READY  out  1  command accepted when VALID&READY at a CLK edge.
- CMD_OP  in  3  000 write, 001 read, 010 run, 011 set bank, 100 set ROMUL, others illegal.
- CMD_ADDR  in  12  CMA address.
- CMD_DATA  in  25  write data, bank select bit [0], or ROMUL value [19:0].
- RSP_VALID  out  1  read data valid.
- RSP_READY  in  1  host accepts read data.
- RSP_DATA  out  25  captured read word.
- EXWE  out  1  CMA write strobe.
- EXRE  out  1  CMA read strobe.
- EXA  out  12  CMA address.
- EXWD  out  25  CMA write data.
- EXRD  in  25  CMA read data.
- EXROMUL  out  20  CMA ROMUL value.
- CBANK  out  1  CMA configuration bank.
- RUN  out  1  CMA run request.
- DONE  in  1  CMA completion.
- BUSY  out  1  high whenever state is not IDLE.
- ERR  out  1  sticky error flag.

Function
REQ-003 The FSM SHALL have the states IDLE, WRITE, READ, RD_CAP, RSP and RUN_WAIT; CMD_READY SHALL be 1 only in IDLE.
REQ-004 Accepting a write SHALL latch EXA and EXWD and enter WRITE; WRITE SHALL assert EXWE for exactly one cycle, then return to IDLE (sustained rate of one write per 2 cycles).
REQ-005 Accepting a read SHALL latch EXA and enter READ, which asserts EXRE for one cycle.
REQ-006 RD_CAP SHALL sample EXRD into RSP_DATA at the end of the cycle following the EXRE cycle, then enter RSP.
REQ-007 RSP SHALL hold RSP_VALID=1 with RSP_DATA stable until RSP_READY=1 is sampled, then return to IDLE.
REQ-008 RSP_DATA SHALL retain its value after the handshake.
REQ-009 Accepting a run SHALL enter RUN_WAIT with RUN=1.
REQ-010 DONE SHALL be ignored in the first RUN_WAIT cycle, which guards against a stale DONE.
REQ-011 From the second RUN_WAIT cycle on, DONE=1 sampled at an edge SHALL clear RUN and return to IDLE at that edge.
REQ-012 A set bank command SHALL update CBANK from CMD_DATA[0] at the accept edge and stay in IDLE.
REQ-013 A set ROMUL command SHALL update EXROMUL from CMD_DATA[19:0] at the accept edge and stay in IDLE.
REQ-014 An illegal CMD_OP SHALL be consumed, set ERR and stay in IDLE, with no CMA strobe.
REQ-015 EXWE, EXRE and RUN SHALL never be high in the same cycle.
REQ-016 CBANK and EXROMUL SHALL remain unchanged by write, read and run commands.
REQ-017 All outputs except CMD_READY and BUSY SHALL come directly from flops; CMD_READY and BUSY SHALL decode only the state register.

Reset
REQ-018 RST_N=0 SHALL immediately force:
- state IDLE;
- EXWE, EXRE, RUN, RSP_VALID, ERR, CBANK = 0;
- EXA, EXWD, EXROMUL, RSP_DATA = 0;
- timeout counter = 0.
REQ-019 Reset asserted mid-operation SHALL drop any in-flight command without completion or response.
REQ-020 CMD_READY SHALL be 1 in the first cycle after reset release.

Configuration
REQ-021 The macro CMA_HOST_TIMEOUT_EN SHALL control the run timeout.
REQ-022 With CMA_HOST_TIMEOUT_EN defined, a 16-bit counter SHALL count RUN_WAIT cycles.
REQ-023 With the macro defined, reaching TIMEOUT_CYC cycles without DONE SHALL clear RUN, set ERR and return to IDLE.
REQ-024 With the macro defined, DONE and timeout in the same cycle SHALL count as DONE, with ERR unchanged.
REQ-025 Without CMA_HOST_TIMEOUT_EN, no counter SHALL exist and RUN_WAIT SHALL wait indefinitely.

Verification
REQ-026 The bench SHALL cover these scenarios:
- Write op, ADDR=0x123, DATA=0x1ABCDEF -> exactly one EXWE cycle with EXA=0x123 and EXWD=0x1ABCDEF; CMD_READY high again 2 cycles after accept.
- Read op, ADDR=0x040, model returns EXRD=0x0055AA1 the cycle after EXRE, RSP_READY held 0 for 3 cycles -> RSP_VALID stays high with 0x0055AA1 stable; drops the cycle after RSP_READY=1.
- DONE held 1 before the run accept, CMA pulses DONE 10 cycles later -> RUN stays high through the first RUN_WAIT cycle and ends at that DONE edge.
- Set bank DATA=1 and set ROMUL DATA=0xFACE5, followed by writes -> CBANK=1 and EXROMUL=0xFACE5 persist; illegal op 111 -> ERR=1, no strobe.
- Macro defined, TIMEOUT_CYC=20, DONE never asserted -> RUN drops after 20 cycles and ERR=1; macro undefined -> RUN still high after 1000 cycles.
- RST_N low during RUN_WAIT and during RSP -> RUN and RSP_VALID drop immediately; CMD_READY=1 after release.
